// File: rtl/layer1_backprop.sv
// layer1_backprop: backward pass for the 2x2 layer-1 datapath.
// Forms leaky-ReLU deltas, accumulates weight/bias gradients over BATCH_LEN
// samples and commits one SGD step per batch into the parameter registers.
// Optional build macro LAYER1_BP_SATURATE_EN: clamp every Q8.8 result to
// [0x8000, 0x7FFF] instead of two's-complement wrap.

package layer1_bp_pkg;
  typedef logic signed [15:0] q88_t;

  typedef struct packed {
    q88_t grad;
    q88_t z;
  } lane_req_t;

  // Bring a wide signed intermediate back to Q8.8 storage width
  function automatic q88_t reduce16(input logic signed [31:0] v);
`ifdef LAYER1_BP_SATURATE_EN
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  // Q8.8 multiply: full product, floor shift by 8, then reduce
  function automatic q88_t qmul(input q88_t a, input q88_t b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return reduce16(p >>> 8);
  endfunction

  function automatic q88_t qadd(input q88_t a, input q88_t b);
    return reduce16(32'(a) + 32'(b));
  endfunction

  function automatic q88_t qsub(input q88_t a, input q88_t b);
    return reduce16(32'(a) - 32'(b));
  endfunction
endpackage

// One output neuron j: delta_j plus its gradient accumulators gw_1j, gw_2j, gb_2j
module layer1_backprop_lane
  import layer1_bp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      beat,
  input  lane_req_t req,
  input  q88_t      leak,
  input  q88_t      x1_q,
  input  q88_t      x2_q,
  input  logic      vld,
  input  logic      clear,
  output q88_t      delta,
  output q88_t      gw1,
  output q88_t      gw2,
  output q88_t      gb
);
  q88_t delta_d;

  // Leaky-ReLU derivative; z == 0 counts as the positive side
  always_comb begin
    delta_d = req.grad;
    if (req.z[15]) delta_d = qmul(req.grad, leak);
  end

  // Stage 1: register delta on an accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      delta <= '0;
    else if (beat) delta <= delta_d;
  end

  // Stage 2: fold the registered delta into the batch accumulators
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gw1 <= '0;
      gw2 <= '0;
      gb  <= '0;
    end else if (clear) begin
      gw1 <= '0;
      gw2 <= '0;
      gb  <= '0;
    end else if (vld) begin
      gw1 <= qadd(gw1, qmul(x1_q, delta));
      gw2 <= qadd(gw2, qmul(x2_q, delta));
      gb  <= qadd(gb, delta);
    end
  end
endmodule

module layer1_backprop
  import layer1_bp_pkg::*;
#(
  parameter int BATCH_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_weights,
  input  logic signed [15:0] init_w11,
  input  logic signed [15:0] init_w12,
  input  logic signed [15:0] init_w21,
  input  logic signed [15:0] init_w22,
  input  logic signed [15:0] init_b21,
  input  logic signed [15:0] init_b22,
  input  logic signed [15:0] leak_factor,
  input  logic signed [15:0] lr,
  input  logic               grad_valid_in,
  output logic               grad_ready,
  input  logic signed [15:0] grad_in1,
  input  logic signed [15:0] grad_in2,
  input  logic signed [15:0] z_in1,
  input  logic signed [15:0] z_in2,
  input  logic signed [15:0] x_in1,
  input  logic signed [15:0] x_in2,
  output logic               delta_valid_out,
  output logic signed [15:0] delta_out1,
  output logic signed [15:0] delta_out2,
  output logic signed [15:0] weight_11,
  output logic signed [15:0] weight_12,
  output logic signed [15:0] weight_21,
  output logic signed [15:0] weight_22,
  output logic signed [15:0] bias_21,
  output logic signed [15:0] bias_22,
  output logic               update_valid
);
  localparam int NUM_LANES = 2;
  localparam int NUM_P     = 6;

  typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_UPDATE, S_DONE} state_t;

  state_t                          state;
  logic [7:0]                      cnt;
  logic [2:0]                      phase;
  logic                            beat;
  logic                            clear;
  logic                            vld_q;
  q88_t                            x1_q, x2_q;
  q88_t                            upd_p;
  lane_req_t [NUM_LANES-1:0]       req;
  logic [NUM_LANES-1:0][15:0]      delta, gw1, gw2, gb;
  // Parameter / gradient order: w11, w12, w21, w22, b21, b22
  logic [NUM_P-1:0][15:0]          params, grads;

  assign beat  = grad_valid_in && grad_ready;
  assign clear = (state == S_DONE);

  assign req[0] = {grad_in1, z_in1};
  assign req[1] = {grad_in2, z_in2};

  // Layer inputs travel alongside the deltas into the accumulate stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q  <= '0;
      x2_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= beat;
      if (beat) begin
        x1_q <= x_in1;
        x2_q <= x_in2;
      end
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    layer1_backprop_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .beat  (beat),
      .req   (req[j]),
      .leak  (leak_factor),
      .x1_q  (x1_q),
      .x2_q  (x2_q),
      .vld   (vld_q),
      .clear (clear),
      .delta (delta[j]),
      .gw1   (gw1[j]),
      .gw2   (gw2[j]),
      .gb    (gb[j])
    );
  end

  assign grads = {gb[1], gb[0], gw2[1], gw2[0], gw1[1], gw1[0]};

  assign delta_valid_out = vld_q;
  assign delta_out1      = delta[0];
  assign delta_out2      = delta[1];

  assign weight_11 = params[0];
  assign weight_12 = params[1];
  assign weight_21 = params[2];
  assign weight_22 = params[3];
  assign bias_21   = params[4];
  assign bias_22   = params[5];

  // SGD step for the parameter selected by the UPDATE phase counter
  always_comb upd_p = qsub(params[phase], qmul(lr, grads[phase]));

  // Batch sequencer: owns count, handshake, parameter commits and update pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_ACCUM;
      cnt          <= '0;
      phase        <= '0;
      grad_ready   <= 1'b1;
      update_valid <= 1'b0;
      params       <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (load_weights)
            params <= {init_b22, init_b21, init_w22, init_w21, init_w12, init_w11};
          if (beat) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(BATCH_LEN - 1)) begin
              state      <= S_DRAIN;
              grad_ready <= 1'b0;
              phase      <= '0;
            end
          end
        end
        // Two idle cycles let the last beat reach the accumulators
        S_DRAIN: begin
          if (phase == 3'd1) begin
            state <= S_UPDATE;
            phase <= '0;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        S_UPDATE: begin
          params[phase] <= upd_p;
          if (phase == 3'(NUM_P - 1)) begin
            state        <= S_DONE;
            phase        <= '0;
            update_valid <= 1'b1;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        S_DONE: begin
          state        <= S_ACCUM;
          cnt          <= '0;
          update_valid <= 1'b0;
          grad_ready   <= 1'b1;
        end
        default: state <= S_ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_layer1_backprop.sv
// Bench for layer1_backprop: random and directed batches against an
// integer-arithmetic model of the delta/gradient/SGD rules.
module tb_layer1_backprop;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_weights;
  logic [15:0] init_w11, init_w12, init_w21, init_w22, init_b21, init_b22;
  logic [15:0] leak_factor, lr;
  logic        grad_valid_in;
  logic        grad_ready;
  logic [15:0] grad_in1, grad_in2, z_in1, z_in2, x_in1, x_in2;
  logic        delta_valid_out;
  logic [15:0] delta_out1, delta_out2;
  logic [15:0] weight_11, weight_12, weight_21, weight_22, bias_21, bias_22;
  logic        update_valid;

  always #5 clk = ~clk;

  layer1_backprop #(.BATCH_LEN(BL)) dut (
    .clk(clk), .rst(rst), .load_weights(load_weights),
    .init_w11(init_w11), .init_w12(init_w12), .init_w21(init_w21),
    .init_w22(init_w22), .init_b21(init_b21), .init_b22(init_b22),
    .leak_factor(leak_factor), .lr(lr),
    .grad_valid_in(grad_valid_in), .grad_ready(grad_ready),
    .grad_in1(grad_in1), .grad_in2(grad_in2), .z_in1(z_in1), .z_in2(z_in2),
    .x_in1(x_in1), .x_in2(x_in2),
    .delta_valid_out(delta_valid_out), .delta_out1(delta_out1), .delta_out2(delta_out2),
    .weight_11(weight_11), .weight_12(weight_12), .weight_21(weight_21),
    .weight_22(weight_22), .bias_21(bias_21), .bias_22(bias_22),
    .update_valid(update_valid)
  );

  int total = 0;
  int bad   = 0;

  // Model state as plain integers
  int m_p[6];
  int m_gw[2][2];
  int m_gb[2];

  logic [15:0] bg1[BL], bg2[BL], bz1[BL], bz2[BL], bx1[BL], bx2[BL];
  logic [15:0] obs_d1[BL], obs_d2[BL];

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int red(input int v);
`ifdef LAYER1_BP_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    int w;
    w = v % 65536;
    if (w < 0) w += 65536;
    if (w >= 32768) w -= 65536;
    return w;
`endif
  endfunction

  function automatic int mulm(input int a, input int b);
    int p, q;
    p = a * b;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return red(q);
  endfunction

  function automatic logic [15:0] dut_param(input int k);
    case (k)
      0: return weight_11;
      1: return weight_12;
      2: return weight_21;
      3: return weight_22;
      4: return bias_21;
      default: return bias_22;
    endcase
  endfunction

  task automatic model_clear_acc();
    for (int i = 0; i < 2; i++) begin
      m_gb[i] = 0;
      for (int j = 0; j < 2; j++) m_gw[i][j] = 0;
    end
  endtask

  task automatic model_beat(input int b, output logic [15:0] e1, output logic [15:0] e2);
    int g[2], z[2], x[2], d[2];
    g[0] = s16(bg1[b]); g[1] = s16(bg2[b]);
    z[0] = s16(bz1[b]); z[1] = s16(bz2[b]);
    x[0] = s16(bx1[b]); x[1] = s16(bx2[b]);
    for (int j = 0; j < 2; j++)
      d[j] = (z[j] >= 0) ? g[j] : mulm(g[j], s16(leak_factor));
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        m_gw[i][j] = red(m_gw[i][j] + mulm(x[i], d[j]));
    for (int j = 0; j < 2; j++) m_gb[j] = red(m_gb[j] + d[j]);
    e1 = 16'(d[0]);
    e2 = 16'(d[1]);
  endtask

  task automatic model_update();
    int g[6];
    g[0] = m_gw[0][0]; g[1] = m_gw[0][1]; g[2] = m_gw[1][0];
    g[3] = m_gw[1][1]; g[4] = m_gb[0];    g[5] = m_gb[1];
    for (int k = 0; k < 6; k++) m_p[k] = red(m_p[k] - mulm(s16(lr), g[k]));
    model_clear_acc();
  endtask

  task automatic check_params(input string tag);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (dut_param(k) !== 16'(m_p[k])) begin
        bad++;
        $display("FAIL %s p%0d: got %h want %h", tag, k, dut_param(k), 16'(m_p[k]));
      end
    end
  endtask

  task automatic do_load();
    load_weights = 1'b1;
    @(posedge clk); #1;
    load_weights = 1'b0;
    m_p[0] = s16(init_w11); m_p[1] = s16(init_w12); m_p[2] = s16(init_w21);
    m_p[3] = s16(init_w22); m_p[4] = s16(init_b21); m_p[5] = s16(init_b22);
    check_params("load");
  endtask

  task automatic rand_beats(input int from);
    for (int b = from; b < BL; b++) begin
      bg1[b] = 16'($urandom); bg2[b] = 16'($urandom);
      bz1[b] = 16'($urandom); bz2[b] = 16'($urandom);
      bx1[b] = 16'($urandom); bx2[b] = 16'($urandom);
    end
  endtask

  task automatic zero_beats(input int from);
    for (int b = from; b < BL; b++) begin
      bg1[b] = '0; bg2[b] = '0; bz1[b] = '0; bz2[b] = '0; bx1[b] = '0; bx2[b] = '0;
    end
  endtask

  // Streams one batch with valid held high, then checks drain timing and the update
  task automatic do_batch(input bit load_drain, input bit abort);
    logic [15:0] e1, e2;
    int t, low, pulses;
    bit seen;
    for (int b = 0; b < BL; b++) begin
      grad_in1 = bg1[b]; grad_in2 = bg2[b];
      z_in1 = bz1[b]; z_in2 = bz2[b];
      x_in1 = bx1[b]; x_in2 = bx2[b];
      grad_valid_in = 1'b1;
      t = 0;
      while (grad_ready !== 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      if (grad_ready !== 1'b1) begin
        total++; bad++;
        $display("FAIL ready_wait: got %b want 1", grad_ready);
      end
      @(posedge clk); #1;
      model_beat(b, e1, e2);
      obs_d1[b] = delta_out1;
      obs_d2[b] = delta_out2;
      total++;
      if (delta_valid_out !== 1'b1 || delta_out1 !== e1 || delta_out2 !== e2) begin
        bad++;
        $display("FAIL delta beat%0d: got v=%b %h %h want v=1 %h %h",
                 b, delta_valid_out, delta_out1, delta_out2, e1, e2);
      end
    end
    grad_valid_in = 1'b0;
    total++;
    if (grad_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_drop: got %b want 0", grad_ready);
    end
    if (abort) begin
      for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      m_p = '{default: 0};
      model_clear_acc();
      check_params("abort");
      total++;
      if (grad_ready !== 1'b1 || update_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_ctl: got rdy=%b upd=%b want rdy=1 upd=0", grad_ready, update_valid);
      end
      #3 rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        if (update_valid !== 1'b0 || grad_ready !== 1'b1) seen = 1'b1;
      end
      total++;
      if (seen) begin
        bad++;
        $display("FAIL abort_quiet: got activity want none");
      end
      return;
    end
    low = 1; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0 && load_drain) begin
        init_w11 = 16'($urandom); init_w12 = 16'($urandom); init_w21 = 16'($urandom);
        init_w22 = 16'($urandom); init_b21 = 16'($urandom); init_b22 = 16'($urandom);
        load_weights = 1'b1;
      end
      @(posedge clk); #1;
      load_weights = 1'b0;
      if (c == 0) check_params("drain_stable");
      if (update_valid === 1'b1) pulses++;
      if (grad_ready === 1'b0) low++;
      else break;
    end
    total++;
    if (low != 9) begin
      bad++;
      $display("FAIL ready_low_cycles: got %0d want 9", low);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL update_pulses: got %0d want 1", pulses);
    end
    model_update();
    check_params("update");
  endtask

  task automatic test_reset();
    check_params("reset");
    total++;
    if (grad_ready !== 1'b1 || delta_valid_out !== 1'b0 || update_valid !== 1'b0 ||
        delta_out1 !== 16'h0 || delta_out2 !== 16'h0) begin
      bad++;
      $display("FAIL reset_ctl: got rdy=%b dv=%b upd=%b d=%h %h want 1 0 0 0 0",
               grad_ready, delta_valid_out, update_valid, delta_out1, delta_out2);
    end
  endtask

  task automatic test_directed();
    init_w11 = 16'h0100; init_w12 = 16'h0; init_w21 = 16'h0100;
    init_w22 = 16'h0;    init_b21 = 16'h0; init_b22 = 16'h0;
    do_load();
    lr = 16'h0080; leak_factor = 16'h0040;
    zero_beats(0);
    bg1[0] = 16'h0100; bz1[0] = 16'h0100; bx1[0] = 16'h0200; bx2[0] = 16'h0100;
    do_batch(1'b0, 1'b0);
    total++;
    if (obs_d1[0] !== 16'h0100) begin
      bad++;
      $display("FAIL dir_delta1: got %h want 0100", obs_d1[0]);
    end
    total++;
    if (weight_11 !== 16'h0000 || weight_21 !== 16'h0080 || bias_21 !== 16'hFF80 ||
        weight_12 !== 16'h0 || weight_22 !== 16'h0 || bias_22 !== 16'h0) begin
      bad++;
      $display("FAIL dir_params: got %h %h %h %h %h %h want 0000 0000 0080 0000 ff80 0000",
               weight_11, weight_12, weight_21, weight_22, bias_21, bias_22);
    end
  endtask

  task automatic test_leak();
    leak_factor = 16'h0040;
    rand_beats(2);
    bg2[0] = 16'h0100; bz2[0] = 16'hFF00; bg1[0] = 16'h0010; bz1[0] = 16'h0; bx1[0] = 16'h0; bx2[0] = 16'h0;
    bg2[1] = 16'h0100; bz2[1] = 16'h0000; bg1[1] = 16'h0; bz1[1] = 16'h0; bx1[1] = 16'h0; bx2[1] = 16'h0;
    do_batch(1'b0, 1'b0);
    total++;
    if (obs_d2[0] !== 16'h0040) begin
      bad++;
      $display("FAIL leak_neg: got %h want 0040", obs_d2[0]);
    end
    total++;
    if (obs_d2[1] !== 16'h0100) begin
      bad++;
      $display("FAIL leak_zero: got %h want 0100", obs_d2[1]);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_w11;
    init_w11 = 16'h0; init_w12 = 16'h0; init_w21 = 16'h0;
    init_w22 = 16'h0; init_b21 = 16'h0; init_b22 = 16'h0;
    do_load();
    lr = 16'h0100;
    zero_beats(0);
    bg1[0] = 16'h7F00; bx1[0] = 16'h7F00; bz1[0] = 16'h0100;
    do_batch(1'b0, 1'b0);
`ifdef LAYER1_BP_SATURATE_EN
    exp_w11 = 16'h8001;
`else
    exp_w11 = 16'hFF00;
`endif
    total++;
    if (weight_11 !== exp_w11) begin
      bad++;
      $display("FAIL sat_w11: got %h want %h", weight_11, exp_w11);
    end
  endtask

  task automatic test_random(input int n);
    for (int r = 0; r < n; r++) begin
      leak_factor = 16'($urandom);
      lr = 16'($urandom);
      rand_beats(0);
      do_batch(1'b0, 1'b0);
    end
  endtask

  task automatic test_load_in_drain();
    init_w11 = 16'($urandom); init_w12 = 16'($urandom); init_w21 = 16'($urandom);
    init_w22 = 16'($urandom); init_b21 = 16'($urandom); init_b22 = 16'($urandom);
    do_load();
    lr = 16'($urandom_range(0, 255));
    rand_beats(0);
    do_batch(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_update();
    init_w11 = 16'h1234; init_w12 = 16'h0567; init_w21 = 16'hF00D;
    init_w22 = 16'h0ABC; init_b21 = 16'h0101; init_b22 = 16'hFEFE;
    do_load();
    lr = 16'h0100;
    rand_beats(0);
    do_batch(1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; load_weights = 1'b0; grad_valid_in = 1'b0;
    init_w11 = '0; init_w12 = '0; init_w21 = '0; init_w22 = '0; init_b21 = '0; init_b22 = '0;
    leak_factor = '0; lr = '0;
    grad_in1 = '0; grad_in2 = '0; z_in1 = '0; z_in2 = '0; x_in1 = '0; x_in2 = '0;
    m_p = '{default: 0};
    model_clear_acc();
    #12;
    test_reset();
    #8 rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_leak();
    test_saturate();
    test_random(3);
    test_load_in_drain();
    test_reset_mid_update();
    test_random(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer1_backprop.md
# layer1_backprop

Backward-pass companion to the 2x2 layer-1 forward datapath (accumulators → systolic array → bias → leaky ReLU). It consumes per-sample output gradients together with the forward pre-activations and layer inputs, then applies the leaky-ReLU derivative to form deltas. Weight and bias gradients are accumulated over a fixed batch, and one SGD update is applied per batch. It owns the trained weight/bias registers that feed the forward layer's `weight_*`/`in_bias_*` ports.

## Interface
- `BATCH_LEN`, 4: samples accumulated per update (1..255).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `load_weights` in 1: load `init_*` into weight/bias registers.
- `init_w11`, `init_w12`, `init_w21`, `init_w22`, `init_b21`, `init_b22` in 16 each: initial values, signed Q8.8.
- `leak_factor` in 16: leaky-ReLU slope for negative inputs, signed Q8.8.
- `lr` in 16: learning rate, signed Q8.8.
- `grad_valid_in` in 1: sample beat valid.
- `grad_ready` out 1: block can accept a beat.
- `grad_in1`, `grad_in2` in 16 each: dL/dy for outputs 1 and 2, signed Q8.8.
- `z_in1`, `z_in2` in 16 each: forward pre-activations (bias output), signed Q8.8.
- `x_in1`, `x_in2` in 16 each: forward layer inputs (`input_11`, `input_21`), signed Q8.8.
- `delta_valid_out` out 1: deltas valid.
- `delta_out1`, `delta_out2` out 16 each: deltas, signed Q8.8.
- `weight_11`, `weight_12`, `weight_21`, `weight_22`, `bias_21`, `bias_22` out 16 each: current parameters.
- `update_valid` out 1: one-cycle pulse when new parameters are committed.

## Operation
- Beat accepted when `grad_valid_in && grad_ready`; the upstream block holds data until accepted.
- Delta: `delta_j = grad_inj` if `z_inj >= 0`, else `mul(grad_inj, leak_factor)`. `z == 0` takes slope 1.
- Gradients: `gw_ij += mul(x_ini, delta_j)` for i,j ∈ {1,2}; `gb_2j += delta_j`. All accumulators are 16-bit Q8.8.
- `mul(a,b)` = 32-bit signed product, arithmetic shift right by 8 (floor), reduced to 16 bits per Configuration. The same rule applies to add/subtract results.
- FSM:
  - ACCUM: `grad_ready=1`; counts accepted beats. When the beat making count = BATCH_LEN is accepted → DRAIN.
  - DRAIN: 2 cycles, `grad_ready=0`, pipeline empties → UPDATE.
  - UPDATE: 6 cycles, one parameter per cycle in order w11, w12, w21, w22, b21, b22. Each is `p ← p − mul(lr, g_p)` → DONE.
  - DONE: 1 cycle. `update_valid=1`, accumulators and count cleared → ACCUM.
- `load_weights` acts only in ACCUM. It overwrites all six parameters next edge and does not disturb accumulators or count. A beat accepted in the same cycle is still processed.
- `load_weights` in DRAIN/UPDATE/DONE is ignored.
- Reset, including mid-batch or mid-UPDATE, aborts all work: state ACCUM, count 0, accumulators 0, parameters 0.

## Timing
- Reset values: `grad_ready=1`, `delta_valid_out=0`, `delta_out*=0`, all parameters 0, `update_valid=0`.
- Beat accepted at edge t → `delta_out*`/`delta_valid_out` at t+1 → accumulators updated at t+2.
- Last beat accepted at edge t: `grad_ready` low from t+1, DRAIN t+1..t+2, UPDATE t+3..t+8, `update_valid` pulses at t+9, `grad_ready` high at t+10.
- Full-batch latency is therefore 10 cycles from last-beat acceptance to `grad_ready` reasserting.
- Back-to-back beats are accepted at one per cycle in ACCUM.
- Parameter outputs change only at UPDATE edges or on `load_weights`. They are stable between updates.

## Configuration
- `LAYER1_BP_SATURATE_EN`:
  - Defined: every `mul`, accumulate and update result clamps to [0x8000, 0x7FFF].
  - Undefined: results keep the low 16 bits (two's-complement wrap).

## Test plan
- BATCH_LEN=1, load w11=w21=0x0100, others 0, lr=0x0080, x=(0x0200,0x0100), z1=0x0100, grad=(0x0100,0) → delta1=0x0100; after update_valid: w11=0x0000, w21=0x0080, b21=0xFF80, others 0.
- Negative pre-activation: z2=0xFF00, leak=0x0040, grad2=0x0100 → delta_out2=0x0040 one cycle after acceptance; z2=0x0000 → delta_out2=0x0100.
- BATCH_LEN=4, `grad_valid_in` held high: `grad_ready` drops after 4th acceptance, stays low exactly 9 cycles, `update_valid` single pulse, accumulator sum of 4 identical beats applied once.
- grad1=0x7F00, x1=0x7F00, z1>0: with `LAYER1_BP_SATURATE_EN` gw11=0x7FFF; without, gw11=0x0100.
- Assert `rst` low during UPDATE cycle 3 → all parameters 0, `grad_ready=1`, no `update_valid`; `load_weights` during DRAIN → ignored, parameters unchanged.
